// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch-target buffer with 2-bit saturating
//               direction counters. IF lookup is combinational; the resolving
//               stage writes back outcomes. Optional statistics counters are
//               enabled by defining BTB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
   parameter int PC_W    = 8,
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = PC_W - IDX_W - 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_en,
   input  logic            inv,
   input  logic [PC_W-1:0] lk_pc,
   output logic            lk_hit,
   output logic            lk_taken,
   output logic [PC_W-1:0] lk_next_pc,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            upd_jump,
   input  logic            upd_mispred,
   output logic [15:0]     stat_updates,
   output logic [15:0]     stat_mispred
);

   localparam logic [PC_W-1:0] c_PC_STEP  = PC_W'(4);
   localparam logic [1:0]      c_CTR_MAX  = 2'b11;
   localparam logic [1:0]      c_CTR_WEAK = 2'b10;

   if (TAG_W < 1) begin : g_tag_w_check
      $error("branch_target_predictor: TAG_W must be at least 1");
   end
   if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_entries_check
      $error("branch_target_predictor: ENTRIES must be a power of two >= 2");
   end

   logic              r_valid  [ENTRIES];
   logic [TAG_W-1:0]  r_tag    [ENTRIES];
   logic [PC_W-1:0]   r_target [ENTRIES];
   logic [1:0]        r_ctr    [ENTRIES];
   logic              r_jump   [ENTRIES];

   logic [IDX_W-1:0]  w_lk_idx;
   logic [TAG_W-1:0]  w_lk_tag;
   logic [IDX_W-1:0]  w_upd_idx;
   logic [TAG_W-1:0]  w_upd_tag;
   logic              w_upd_acc;
   logic              w_upd_hit;
   logic              w_wr_en;
   logic [TAG_W-1:0]  w_nx_tag;
   logic [PC_W-1:0]   w_nx_target;
   logic [1:0]        w_nx_ctr;
   logic              w_nx_jump;
   logic              w_unused_bits;

   // Lookup path: pure function of lk_pc and current table, no bypass.
   assign w_lk_idx   = lk_pc[IDX_W+1:2];
   assign w_lk_tag   = lk_pc[PC_W-1:IDX_W+2];
   assign lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign lk_taken   = lk_hit && (r_jump[w_lk_idx] || r_ctr[w_lk_idx][1]);
   assign lk_next_pc = lk_taken ? r_target[w_lk_idx] : (lk_pc + c_PC_STEP);

   assign w_upd_idx = upd_pc[IDX_W+1:2];
   assign w_upd_tag = upd_pc[PC_W-1:IDX_W+2];
   assign w_upd_acc = upd_valid && pc_en && !inv;
   assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

   always_comb begin
      w_wr_en     = 1'b0;
      w_nx_tag    = r_tag[w_upd_idx];
      w_nx_target = r_target[w_upd_idx];
      w_nx_ctr    = r_ctr[w_upd_idx];
      w_nx_jump   = r_jump[w_upd_idx];
      if (w_upd_acc) begin
         if (w_upd_hit) begin
            w_wr_en = 1'b1;
            if (upd_jump) begin
               w_nx_ctr    = c_CTR_MAX;
               w_nx_jump   = 1'b1;
               w_nx_target = upd_target;
            end else if (upd_taken) begin
               w_nx_ctr    = (r_ctr[w_upd_idx] == c_CTR_MAX) ? c_CTR_MAX
                                                             : r_ctr[w_upd_idx] + 2'd1;
               w_nx_target = upd_target;
            end else begin
               w_nx_ctr    = (r_ctr[w_upd_idx] == 2'd0) ? 2'd0
                                                        : r_ctr[w_upd_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            // Only taken outcomes allocate; any alias at this index is evicted.
            w_wr_en     = 1'b1;
            w_nx_tag    = w_upd_tag;
            w_nx_target = upd_target;
            w_nx_jump   = upd_jump;
            w_nx_ctr    = upd_jump ? c_CTR_MAX : c_CTR_WEAK;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'd0;
            r_jump[i]   <= 1'b0;
         end
      end else if (pc_en) begin
         if (inv) begin
            for (int i = 0; i < ENTRIES; i++) begin
               r_valid[i] <= 1'b0;
            end
         end else if (w_wr_en) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_nx_tag;
            r_target[w_upd_idx] <= w_nx_target;
            r_ctr[w_upd_idx]    <= w_nx_ctr;
            r_jump[w_upd_idx]   <= w_nx_jump;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic [15:0] r_stat_updates;
   logic [15:0] r_stat_mispred;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_updates <= 16'h0000;
         r_stat_mispred <= 16'h0000;
      end else if (w_upd_acc) begin
         if (r_stat_updates != 16'hFFFF) begin
            r_stat_updates <= r_stat_updates + 16'd1;
         end
         if (upd_mispred && (r_stat_mispred != 16'hFFFF)) begin
            r_stat_mispred <= r_stat_mispred + 16'd1;
         end
      end
   end

   assign stat_updates  = r_stat_updates;
   assign stat_mispred  = r_stat_mispred;
   assign w_unused_bits = ^upd_pc[1:0];
`else
   assign stat_updates  = 16'h0000;
   assign stat_mispred  = 16'h0000;
   assign w_unused_bits = ^{upd_pc[1:0], upd_mispred};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// Bench for branch_target_predictor: directed lookups/updates, expectations
// queued by the stimulus and checked by a separate negedge monitor.
module tb_branch_target_predictor;

   typedef struct packed {
      logic [7:0]  pc;
      logic        hit;
      logic        taken;
      logic [7:0]  next;
      logic [15:0] su;
      logic [15:0] sm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_en;
   logic        inv;
   logic [7:0]  lk_pc;
   logic        lk_hit;
   logic        lk_taken;
   logic [7:0]  lk_next_pc;
   logic        upd_valid;
   logic [7:0]  upd_pc;
   logic [7:0]  upd_target;
   logic        upd_taken;
   logic        upd_jump;
   logic        upd_mispred;
   logic [15:0] stat_updates;
   logic [15:0] stat_mispred;

   logic        chk = 1'b0;
   logic        fin = 1'b0;
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_su = 16'h0;
   logic [15:0] m_sm = 16'h0;

   branch_target_predictor #(.PC_W(8), .ENTRIES(16)) dut (
      .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .inv(inv),
      .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_next_pc(lk_next_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_jump(upd_jump), .upd_mispred(upd_mispred),
      .stat_updates(stat_updates), .stat_mispred(stat_mispred)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Monitor: pops one expectation per presented lookup.
   always @(negedge clk) begin
      exp_t e;
      if (chk) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard underflow at pc=%h", lk_pc);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (lk_hit !== e.hit) begin
               errors++; $display("FAIL hit pc=%h got %b exp %b", e.pc, lk_hit, e.hit);
            end
            checks++;
            if (lk_taken !== e.taken) begin
               errors++; $display("FAIL taken pc=%h got %b exp %b", e.pc, lk_taken, e.taken);
            end
            checks++;
            if (lk_next_pc !== e.next) begin
               errors++; $display("FAIL next_pc pc=%h got %h exp %h", e.pc, lk_next_pc, e.next);
            end
            checks++;
            if (stat_updates !== e.su) begin
               errors++; $display("FAIL stat_updates pc=%h got %0d exp %0d", e.pc, stat_updates, e.su);
            end
            checks++;
            if (stat_mispred !== e.sm) begin
               errors++; $display("FAIL stat_mispred pc=%h got %0d exp %0d", e.pc, stat_mispred, e.sm);
            end
         end
      end
      if (fin) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard leftover got %0d exp 0", exp_q.size());
         end
      end
   end

   task automatic look(input logic [7:0] pc, input logic h, input logic t, input logic [7:0] n);
      exp_t e;
      lk_pc = pc;
      e.pc = pc; e.hit = h; e.taken = t; e.next = n;
`ifdef BTB_STATS_EN
      e.su = m_su; e.sm = m_sm;
`else
      e.su = 16'h0; e.sm = 16'h0;
`endif
      exp_q.push_back(e);
      chk = 1'b1;
      @(negedge clk);
      #1 chk = 1'b0;
   endtask

   task automatic count_upd(input logic mp);
      if (pc_en && !inv) begin
         if (m_su != 16'hFFFF) m_su = m_su + 16'd1;
         if (mp && (m_sm != 16'hFFFF)) m_sm = m_sm + 16'd1;
      end
   endtask

   task automatic drive_upd(input logic [7:0] pc, input logic [7:0] tgt,
                            input logic tk, input logic jp, input logic mp);
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
      upd_taken = tk; upd_jump = jp; upd_mispred = mp;
   endtask

   task automatic upd(input logic [7:0] pc, input logic [7:0] tgt,
                      input logic tk, input logic jp, input logic mp);
      drive_upd(pc, tgt, tk, jp, mp);
      count_upd(mp);
      @(posedge clk);
      #1 upd_valid = 1'b0; inv = 1'b0;
   endtask

   // Update and lookup of the same PC in the same cycle: lookup sees old contents.
   task automatic upd_look(input logic [7:0] pc, input logic [7:0] tgt,
                           input logic tk, input logic jp, input logic mp,
                           input logic h, input logic t, input logic [7:0] n);
      @(posedge clk);
      #1 drive_upd(pc, tgt, tk, jp, mp);
      look(pc, h, t, n);
      count_upd(mp);
      @(posedge clk);
      #1 upd_valid = 1'b0; inv = 1'b0;
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      m_su = 16'h0; m_sm = 16'h0;
      look(8'h24, 1'b0, 1'b0, 8'h28);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; pc_en = 1'b1; inv = 1'b0; lk_pc = 8'h00;
      upd_valid = 1'b0; upd_pc = 8'h00; upd_target = 8'h00;
      upd_taken = 1'b0; upd_jump = 1'b0; upd_mispred = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Empty table: sequential prediction, including wrap.
      look(8'h24, 1'b0, 1'b0, 8'h28);
      look(8'hFC, 1'b0, 1'b0, 8'h00);

      // Allocate 0x24 -> 0x40; same-cycle lookup still misses.
      upd_look(8'h24, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h28);
      look(8'h24, 1'b1, 1'b1, 8'h40);
      look(8'h27, 1'b1, 1'b1, 8'h40);
      upd(8'h24, 8'h40, 1'b0, 1'b0, 1'b0);
      look(8'h24, 1'b1, 1'b0, 8'h28);
      upd(8'h24, 8'h40, 1'b0, 1'b0, 1'b0);
      look(8'h24, 1'b1, 1'b0, 8'h28);
      upd(8'h24, 8'h40, 1'b0, 1'b0, 1'b0);
      upd(8'h24, 8'h44, 1'b1, 1'b0, 1'b0);
      look(8'h24, 1'b1, 1'b0, 8'h28);
      upd(8'h24, 8'h44, 1'b1, 1'b0, 1'b1);
      look(8'h24, 1'b1, 1'b1, 8'h44);
      upd(8'h24, 8'h44, 1'b1, 1'b0, 1'b0);
      upd(8'h24, 8'h44, 1'b1, 1'b0, 1'b0);
      upd(8'h24, 8'h99, 1'b0, 1'b0, 1'b0);
      look(8'h24, 1'b1, 1'b1, 8'h44);
      upd(8'h24, 8'h99, 1'b0, 1'b0, 1'b0);
      look(8'h24, 1'b1, 1'b0, 8'h28);

      // Alias at index 9 evicts 0x24.
      upd(8'h64, 8'h80, 1'b1, 1'b0, 1'b0);
      look(8'h24, 1'b0, 1'b0, 8'h28);
      look(8'h64, 1'b1, 1'b1, 8'h80);

      // Jump entry stays taken despite not-taken branch updates.
      upd(8'h30, 8'h10, 1'b1, 1'b1, 1'b1);
      look(8'h30, 1'b1, 1'b1, 8'h10);
      for (int i = 0; i < 3; i++) upd(8'h30, 8'h10, 1'b0, 1'b0, 1'b0);
      look(8'h30, 1'b1, 1'b1, 8'h10);
      upd(8'h30, 8'h20, 1'b1, 1'b1, 1'b0);
      look(8'h30, 1'b1, 1'b1, 8'h20);

      // Not-taken miss never allocates.
      upd(8'h08, 8'h70, 1'b0, 1'b0, 1'b0);
      look(8'h08, 1'b0, 1'b0, 8'h0C);

      // pc_en low freezes everything, including inv and statistics.
      pc_en = 1'b0; inv = 1'b1;
      upd(8'h50, 8'h60, 1'b1, 1'b0, 1'b1);
      pc_en = 1'b1;
      look(8'h50, 1'b0, 1'b0, 8'h54);
      look(8'h64, 1'b1, 1'b1, 8'h80);

      // inv wins over a simultaneous update.
      inv = 1'b1;
      upd(8'h50, 8'h60, 1'b1, 1'b0, 1'b1);
      look(8'h50, 1'b0, 1'b0, 8'h54);
      look(8'h64, 1'b0, 1'b0, 8'h68);
      look(8'h30, 1'b0, 1'b0, 8'h34);

      // Statistics: 5 accepted updates, 2 mispredicted; async reset clears.
      mid_reset();
      upd(8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
      upd(8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
      pc_en = 1'b0;
      upd(8'h14, 8'h00, 1'b1, 1'b0, 1'b1);
      pc_en = 1'b1;
      upd(8'h18, 8'h00, 1'b1, 1'b1, 1'b0);
      upd(8'h1C, 8'h00, 1'b0, 1'b0, 1'b1);
      upd(8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
      look(8'h18, 1'b1, 1'b1, 8'h00);
      mid_reset();
      look(8'h18, 1'b0, 1'b0, 8'h1C);

      repeat (2) @(posedge clk);
      fin = 1'b1;
      @(negedge clk);
      #1 fin = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch-target buffer with 2-bit saturating direction counters. It replaces the static PC+4 prediction in the IF stage of the pipelined RV32I core. IF looks up the current PC combinationally and receives a predicted next PC. The resolving stage writes back each control-transfer outcome. A taken hit lets IF redirect in the same cycle, so no flush is needed on a correctly predicted branch or jump.

## Interface
- `PC_W`, default 8: PC width in bits.
- `ENTRIES`, default 16: table entries. Must be a power of two and ≥ 2.
- `IDX_W`, default $clog2(ENTRIES): index width. Derived; do not override.
- `TAG_W`, default PC_W-IDX_W-2: tag width. Derived. Elaboration error if < 1.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc_en`  in  1: global advance enable. When low, table and statistics state are frozen.
- `inv`  in  1: invalidate every entry.
- `lk_pc`  in  PC_W: IF-stage PC to look up.
- `lk_hit`  out  1: valid entry with matching tag.
- `lk_taken`  out  1: prediction is taken.
- `lk_next_pc`  out  PC_W: predicted next PC.
- `upd_valid`  in  1: resolved control-transfer outcome is present.
- `upd_pc`  in  PC_W: PC of the resolved instruction.
- `upd_target`  in  PC_W: resolved target.
- `upd_taken`  in  1: actual direction.
- `upd_jump`  in  1: instruction is JAL/JALR (unconditional).
- `upd_mispred`  in  1: the pipeline redirected on this instruction.
- `stat_updates`  out  16: accepted updates (feature-gated).
- `stat_mispred`  out  16: accepted mispredictions (feature-gated).

## Operation
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[PC_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target[PC_W], ctr[2], jump.
- Lookup (combinational):
  - lk_hit = valid && tag match.
  - lk_taken = lk_hit && (jump || ctr[1]).
  - lk_next_pc = lk_taken ? target : lk_pc+4, truncated to PC_W (wraps).
- An update is accepted when upd_valid && pc_en && !inv.
- Accepted update, hit at upd_pc:
  - upd_jump=1: ctr ← 2'b11, jump ← 1, target ← upd_target.
  - Conditional branch, taken: ctr saturating-increments (max 3) and target ← upd_target.
  - Conditional branch, not taken: ctr saturating-decrements (min 0); target is unchanged.
- Accepted update, miss:
  - upd_taken=1: allocate the entry (overwriting any alias). valid ← 1, tag ← upd tag, target ← upd_target, jump ← upd_jump, ctr ← upd_jump ? 2'b11 : 2'b10.
  - upd_taken=0: no change; not-taken branches are never allocated.
- inv && pc_en: all valid bits cleared at the edge. A simultaneous update is dropped. Statistics are not cleared.
- Reset: all valid=0, ctr=0, jump=0, target=0, tag=0, statistics=0.

## Timing
- Lookup has zero latency: outputs are a pure function of lk_pc and the current table.
- An update becomes visible on the cycle after its rising edge. A same-cycle lookup of the same index sees the old contents; there is no bypass.
- Exactly one table write per cycle.
- rst_n assertion clears state immediately, independent of clk.
- With all entries invalid, the output is the sequential prediction: lk_next_pc = lk_pc+4, lk_hit=0, lk_taken=0.
- pc_en=0 blocks both inv and updates.

## Configuration
- `BTB_STATS_EN` defined:
  - stat_updates increments on every accepted update.
  - stat_mispred increments on every accepted update with upd_mispred=1.
  - Both saturate at 16'hFFFF and are cleared only by rst_n.
- `BTB_STATS_EN` undefined: both stat ports are tied to 16'h0000 and the counters are not synthesised.

## Test plan
All scenarios use PC_W=8, ENTRIES=16.
- Reset, then lk_pc=0x24 → lk_hit=0, lk_taken=0, lk_next_pc=0x28. lk_pc=0xFC → lk_next_pc=0x00 (wrap).
- Update pc=0x24, target=0x40, taken, branch. Next cycle lk_pc=0x24 → hit, taken, next_pc=0x40.
  - Two further not-taken updates → ctr=0, lk_taken=0, next_pc=0x28.
  - Three taken updates → ctr=3. One not-taken → still predicts 0x40.
- Aliasing: after 0x24 is allocated, a taken update pc=0x64, target=0x80 (same index 9, tag 1) → lk_pc=0x24 misses; lk_pc=0x64 → next_pc=0x80.
- JAL update pc=0x30, target=0x10, jump. Then three not-taken branch updates to 0x30 → still taken to 0x10 while jump=1.
- inv and a taken update to 0x50 in the same cycle → afterwards every lookup misses, including 0x50. pc_en=0 with an update → no change.
- With BTB_STATS_EN: 5 accepted updates, 2 with upd_mispred → stat_updates=5, stat_mispred=2. Assert rst_n low mid-run → both 0 immediately. Without the macro → both ports always 0.
